// File: rtl/axi_stream_extract_header_pkg.sv
// Purpose: shared FSM encoding and byte-lane constants for the AXI-Stream header extractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_stream_extract_header_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a header-length config
    ST_HEAD  = 2'd1,  // next beat carries the header
    ST_BODY  = 2'd2,  // re-aligning payload beats
    ST_FLUSH = 2'd3   // emitting the final carry-only beat
  } state_t;

endpackage

// File: rtl/axi_stream_extract_header_reg_slice.sv
// Purpose: single-entry valid/ready register stage; data cleared to zero when the entry drains.
// Latency: 1 cycle from in handshake to out_vld.
// Backpressure: in_rdy = entry empty or being drained this cycle; out_vld/out_dat held stable while !out_rdy.
// Ports: in_vld/in_dat/in_rdy (upstream), out_vld/out_dat/out_rdy (downstream).
module axi_stream_extract_header_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Purpose: strip the leading 1..DATA_BYTE_WD header bytes of each packet onto a header port and
//          re-align the remaining payload MSB-first on the output stream.
// Latency: header and payload each 1 cycle after input acceptance; backpressure: header and payload
//          ports independent, input stalls while the needed output register is occupied.
// Ports: valid_cnt/byte_extract_cnt/ready_cnt (per-packet header length H = cnt+1),
//        *_in (ingress stream), *_out (payload stream), *_header (LSB-aligned header, unused lanes zero).
module axi_stream_extract_header
  import axi_stream_extract_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_cnt,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    ready_cnt,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
);

  typedef struct packed {
    logic [DATA_WD-1:0]      dat;
    logic [DATA_BYTE_WD-1:0] keep;
    logic                    last;
  } pay_t;

  typedef struct packed {
    logic [DATA_WD-1:0]      dat;
    logic [DATA_BYTE_WD-1:0] keep;
  } hdr_t;

  // Expand a byte-lane keep mask to a bit mask so invalid lanes are forced to zero.
  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*BYTE_W +: BYTE_W] = {BYTE_W{k[i]}};
    return m;
  endfunction

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q;
  logic [DATA_WD-1:0]      carry_q;
  logic [DATA_BYTE_WD-1:0] carry_keep_q;

  int                      h_bytes, s_bytes;
  logic [DATA_WD-1:0]      carry_nxt, hdr_part;
  logic [DATA_BYTE_WD-1:0] carry_keep_nxt, hdr_keep_part, top_s_keep;
  logic                    has_tail, in_fire;

  logic pay_in_vld, pay_in_rdy, hdr_in_vld, hdr_in_rdy;
  pay_t pay_in_dat, pay_out_dat;
  hdr_t hdr_in_dat, hdr_out_dat;

  // Byte-lane arithmetic. The carry is kept left-aligned (its S bytes in the top lanes), so a body
  // beat is just carry | (top H bytes of data_in moved to the bottom). With H = DATA_BYTE_WD the
  // shifts run the full width and the carry is always zero, giving a straight pass-through.
  always_comb begin
    h_bytes        = int'(cnt_q) + 1;
    s_bytes        = DATA_BYTE_WD - h_bytes;
    carry_nxt      = data_in << (BYTE_W * h_bytes);
    carry_keep_nxt = keep_in << h_bytes;
    hdr_part       = data_in >> (BYTE_W * s_bytes);
    hdr_keep_part  = keep_in >> s_bytes;
    top_s_keep     = ~({DATA_BYTE_WD{1'b1}} >> s_bytes);
    // Bytes beyond the first H lanes of this beat survive into the next output beat.
    has_tail       = |carry_keep_nxt;
  end

  assign in_fire = valid_in && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_cnt) state_d = ST_HEAD;
      ST_HEAD:  if (in_fire) state_d = last_in ? ST_IDLE : ST_BODY;
      ST_BODY:  if (in_fire && last_in) state_d = has_tail ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: if (pay_in_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_cnt  = 1'b0;
    ready_in   = 1'b0;
    pay_in_vld = 1'b0;
    pay_in_dat = '0;
    hdr_in_vld = 1'b0;
    hdr_in_dat = '0;
    case (state_q)
      ST_IDLE: ready_cnt = 1'b1;
      ST_HEAD: begin
        // Both registers must be free: a short last beat may need header and payload at once.
        ready_in        = hdr_in_rdy && pay_in_rdy;
        hdr_in_vld      = valid_in && hdr_in_rdy && pay_in_rdy;
        // keep_in shifted down keeps only the header lanes actually received on a short packet.
        hdr_in_dat.keep = hdr_keep_part;
        hdr_in_dat.dat  = hdr_part & lane_mask(hdr_keep_part);
        pay_in_vld      = valid_in && hdr_in_rdy && pay_in_rdy && last_in && has_tail;
        pay_in_dat.keep = carry_keep_nxt;
        pay_in_dat.dat  = carry_nxt & lane_mask(carry_keep_nxt);
        pay_in_dat.last = 1'b1;
      end
      ST_BODY: begin
        ready_in        = pay_in_rdy;
        pay_in_vld      = valid_in && pay_in_rdy;
        pay_in_dat.keep = top_s_keep | hdr_keep_part;
        pay_in_dat.dat  = (carry_q | hdr_part) & lane_mask(top_s_keep | hdr_keep_part);
        pay_in_dat.last = last_in && !has_tail;
      end
      ST_FLUSH: begin
        pay_in_vld      = 1'b1;
        pay_in_dat.keep = carry_keep_q;
        pay_in_dat.dat  = carry_q & lane_mask(carry_keep_q);
        pay_in_dat.last = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      carry_q      <= '0;
      carry_keep_q <= '0;
    end else begin
      if (state_q == ST_IDLE && valid_cnt) cnt_q <= byte_extract_cnt;
      if (in_fire && (state_q == ST_HEAD || state_q == ST_BODY)) begin
        carry_q      <= carry_nxt;
        carry_keep_q <= carry_keep_nxt;
      end
    end
  end

  axi_stream_extract_header_reg_slice #(.WIDTH($bits(pay_t))) u_pay_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (pay_in_vld),
    .in_dat  (pay_in_dat),
    .in_rdy  (pay_in_rdy),
    .out_vld (valid_out),
    .out_dat (pay_out_dat),
    .out_rdy (ready_out)
  );

  axi_stream_extract_header_reg_slice #(.WIDTH($bits(hdr_t))) u_hdr_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (hdr_in_vld),
    .in_dat  (hdr_in_dat),
    .in_rdy  (hdr_in_rdy),
    .out_vld (valid_header),
    .out_dat (hdr_out_dat),
    .out_rdy (ready_header)
  );

  assign data_out    = pay_out_dat.dat;
  assign keep_out    = pay_out_dat.keep;
  assign last_out    = pay_out_dat.last;
  assign data_header = hdr_out_dat.dat;
  assign keep_header = hdr_out_dat.keep;

endmodule
